// File: rtl/bus_sync_filt_pkg.sv
// bus_sync_filt_pkg: default parameters and width/slice helpers for the bus synchroniser filter
package bus_sync_filt_pkg;
  localparam int DEF_BUS_WIDTH   = 8;
  localparam int DEF_NUM_CHAN    = 1;
  localparam int DEF_NUM_RETIME  = 2;
  localparam int DEF_STABLE_CNT  = 1;
  localparam int DEF_TIMEOUT_CYC = 256;
  function automatic int cnt_w(int stable_cnt);
    return $clog2(stable_cnt + 1);
  endfunction
  function automatic int tcnt_w(int timeout_cyc);
    return $clog2(timeout_cyc + 1);
  endfunction
  function automatic int chan_slice(int c, int w = DEF_BUS_WIDTH);
    return c * w;
  endfunction
endpackage

// File: rtl/bits_sync.sv
// bits_sync: N-deep unreset retiming chain for a W-bit bus
module bits_sync #(
  parameter int W = 1,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] r_q [N];
  always_ff @(posedge clk) begin
    r_q[0] <= d;
    for (int i = 1; i < N; i++) r_q[i] <= r_q[i-1];
  end
  assign q = r_q[N-1];
endmodule

// File: rtl/bus_sync_filt_chan.sv
// bus_sync_filt_chan: one channel of retime, stability filter, update strobe and optional
// sticky timeout (enabled by BUS_SYNC_FILT_TIMEOUT_EN)
module bus_sync_filt_chan
  import bus_sync_filt_pkg::*;
#(
  parameter int                   BUS_WIDTH   = DEF_BUS_WIDTH,
  parameter int                   NUM_RETIME  = DEF_NUM_RETIME,
  parameter int                   STABLE_CNT  = DEF_STABLE_CNT,
  parameter logic [BUS_WIDTH-1:0] RESET_VAL   = '0,
  parameter int                   TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] d,
  output logic [BUS_WIDTH-1:0] q,
  output logic                 upd,
  output logic                 stable,
  output logic                 timeout
);
  localparam int CW = cnt_w(STABLE_CNT);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CNT);
  if (NUM_RETIME < 2 || STABLE_CNT < 1 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("bus_sync_filt_chan: illegal parameter value");
  end
  logic [BUS_WIDTH-1:0] s, p_q, p_d, data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic upd_q, upd_d, stable_q, stable_d, fire;
  bits_sync #(.W(BUS_WIDTH), .N(NUM_RETIME)) u_sync (.clk(clk), .d(d), .q(s));
  always_comb begin
    fire     = (s == p_q) && (cnt_q == CMAX - 1'b1) && (s != data_q);
    p_d      = s;
    cnt_d    = (s != p_q) ? '0 : (cnt_q < CMAX) ? cnt_q + 1'b1 : cnt_q;
    data_d   = fire ? s : data_q;
    upd_d    = fire;
    stable_d = cnt_d == CMAX;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q      <= RESET_VAL;
      cnt_q    <= '0;
      data_q   <= RESET_VAL;
      upd_q    <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      upd_q    <= upd_d;
      stable_q <= stable_d;
    end
  end
  assign q      = data_q;
  assign upd    = upd_q;
  assign stable = stable_q;
`ifdef BUS_SYNC_FILT_TIMEOUT_EN
  localparam int TW = tcnt_w(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic to_q, to_d;
  always_comb begin
    tcnt_d = stable_q ? '0 : (tcnt_q < TMAX) ? tcnt_q + 1'b1 : tcnt_q;
    to_d   = to_q | (tcnt_q == TMAX);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= '0;
      to_q   <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      to_q   <= to_d;
    end
  end
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif
endmodule

// File: rtl/bus_sync_filt.sv
// bus_sync_filt: multi-channel stability-gated bus synchroniser into i_clk_b;
// optional sticky per-channel timeout enabled by BUS_SYNC_FILT_TIMEOUT_EN
module bus_sync_filt
  import bus_sync_filt_pkg::*;
#(
  parameter int                   BUS_WIDTH   = DEF_BUS_WIDTH,
  parameter int                   NUM_CHAN    = DEF_NUM_CHAN,
  parameter int                   NUM_RETIME  = DEF_NUM_RETIME,
  parameter int                   STABLE_CNT  = DEF_STABLE_CNT,
  parameter logic [BUS_WIDTH-1:0] RESET_VAL   = '0,
  parameter int                   TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                          i_clk_b,
  input  logic                          i_rst_b,
  input  logic [NUM_CHAN*BUS_WIDTH-1:0] i_data_a,
  output logic [NUM_CHAN*BUS_WIDTH-1:0] o_data_b,
  output logic [NUM_CHAN-1:0]           o_update_b,
  output logic [NUM_CHAN-1:0]           o_stable_b,
  output logic [NUM_CHAN-1:0]           o_timeout_b
);
  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
    bus_sync_filt_chan #(
      .BUS_WIDTH  (BUS_WIDTH),
      .NUM_RETIME (NUM_RETIME),
      .STABLE_CNT (STABLE_CNT),
      .RESET_VAL  (RESET_VAL),
      .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_chan (
      .clk    (i_clk_b),
      .rst    (i_rst_b),
      .d      (i_data_a[chan_slice(c, BUS_WIDTH) +: BUS_WIDTH]),
      .q      (o_data_b[chan_slice(c, BUS_WIDTH) +: BUS_WIDTH]),
      .upd    (o_update_b[c]),
      .stable (o_stable_b[c]),
      .timeout(o_timeout_b[c])
    );
  end
endmodule
